// File: rtl/age_matrix_multi_selector.sv
// Oldest-first multi-port selector: valid vector plus DEPTH x DEPTH age matrix, multi-port enqueue.
// Select is combinational (zero latency); a select port frees its entry only when sel_ready accepts it.
module age_matrix_multi_selector #(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 2,
  parameter int SEL_WIDTH = 2,
  parameter int IDX_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ENQ_WIDTH-1:0]           enq_en,
  input  logic [ENQ_WIDTH*IDX_WIDTH-1:0] enq_idx,
  input  logic [DEPTH-1:0]               ready,
  input  logic                           flush_en,
  input  logic [DEPTH-1:0]               flush_mask,
  output logic [SEL_WIDTH-1:0]           sel_valid,
  output logic [SEL_WIDTH*IDX_WIDTH-1:0] sel_idx,
  output logic [SEL_WIDTH*DEPTH-1:0]     sel_onehot,
  input  logic [SEL_WIDTH-1:0]           sel_ready,
  output logic [DEPTH-1:0]               entry_valid,
  output logic [CNT_WIDTH-1:0]           count
);

  logic [DEPTH-1:0]     valid_q, valid_n;
  logic [DEPTH-1:0]     older_q [DEPTH];
  logic [DEPTH-1:0]     older_n [DEPTH];
  logic [CNT_WIDTH-1:0] count_q, count_n;
  logic [DEPTH-1:0]     elig;
  logic [CNT_WIDTH-1:0] rank [DEPTH];
  logic [CNT_WIDTH-1:0] n_elig;
  logic [DEPTH-1:0]     fire_vec;
  logic [DEPTH-1:0]     flush_vec;
  logic [DEPTH-1:0]     enq_vec;

  // rank[i] counts eligible entries older than i; port k takes the entry of rank k.
  always_comb begin
    elig   = valid_q & ready;
    n_elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_elig  = n_elig + CNT_WIDTH'(elig[i]);
      rank[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && older_q[j][i]) begin
          rank[i] = rank[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    sel_valid  = '0;
    sel_idx    = '0;
    sel_onehot = '0;
    fire_vec   = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      sel_valid[k] = n_elig > CNT_WIDTH'(k);
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_valid[k] && elig[i] && rank[i] == CNT_WIDTH'(k)) begin
          sel_onehot[k*DEPTH + i] = 1'b1;
          sel_idx[k*IDX_WIDTH +: IDX_WIDTH] = sel_idx[k*IDX_WIDTH +: IDX_WIDTH] | IDX_WIDTH'(i);
          if (sel_ready[k]) begin
            fire_vec[i] = 1'b1;
          end
        end
      end
    end
  end

  // Enqueue is applied last so it wins over fire/flush of the same entry.
  // Processing ports in ascending order makes the lower port the older one.
  always_comb begin
    flush_vec = flush_en ? flush_mask : '0;
    enq_vec   = '0;
    older_n   = older_q;
    for (int p = 0; p < ENQ_WIDTH; p++) begin
      if (enq_en[p]) begin
        enq_vec[enq_idx[p*IDX_WIDTH +: IDX_WIDTH]] = 1'b1;
        older_n[enq_idx[p*IDX_WIDTH +: IDX_WIDTH]] = '0;
        for (int i = 0; i < DEPTH; i++) begin
          older_n[i][enq_idx[p*IDX_WIDTH +: IDX_WIDTH]] = 1'b1;
        end
      end
    end
    valid_n = (valid_q & ~fire_vec & ~flush_vec) | enq_vec;
    count_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_n = count_n + CNT_WIDTH'(valid_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      older_q <= '{default: '0};
    end else begin
      valid_q <= valid_n;
      count_q <= count_n;
      older_q <= older_n;
    end
  end

  assign entry_valid = valid_q;
  assign count       = count_q;

  // Illegal-usage detection for simulation only; the datapath does not recover.
  logic busy_enq;
  logic dup_enq;
  int   n_enq;
  int   n_free;

  always_comb begin
    busy_enq = 1'b0;
    dup_enq  = 1'b0;
    n_enq    = 0;
    n_free   = 0;
    for (int p = 0; p < ENQ_WIDTH; p++) begin
      if (enq_en[p]) begin
        n_enq = n_enq + 1;
        if (valid_q[enq_idx[p*IDX_WIDTH +: IDX_WIDTH]] &&
            !fire_vec[enq_idx[p*IDX_WIDTH +: IDX_WIDTH]] &&
            !flush_vec[enq_idx[p*IDX_WIDTH +: IDX_WIDTH]]) begin
          busy_enq = 1'b1;
        end
        for (int q = p + 1; q < ENQ_WIDTH; q++) begin
          if (enq_en[q] && enq_idx[q*IDX_WIDTH +: IDX_WIDTH] == enq_idx[p*IDX_WIDTH +: IDX_WIDTH]) begin
            dup_enq = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (fire_vec[i] || flush_vec[i])) begin
        n_free = n_free + 1;
      end
    end
  end

  a_enq_busy:  assert property (@(posedge clk) disable iff (rst) !busy_enq);
  a_enq_dup:   assert property (@(posedge clk) disable iff (rst) !dup_enq);
  a_enq_over:  assert property (@(posedge clk) disable iff (rst) (int'(count_q) + n_enq - n_free) <= DEPTH);

endmodule

// File: tb/tb_age_matrix_multi_selector.sv
// Directed bench for age_matrix_multi_selector: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_age_matrix_multi_selector;

  logic        clk;
  logic        rst;
  logic [1:0]  enq_en;
  logic [7:0]  enq_idx;
  logic [15:0] ready;
  logic        flush_en;
  logic [15:0] flush_mask;
  logic [1:0]  sel_valid;
  logic [7:0]  sel_idx;
  logic [31:0] sel_onehot;
  logic [1:0]  sel_ready;
  logic [15:0] entry_valid;
  logic [4:0]  count;

  age_matrix_multi_selector #(
    .DEPTH(16), .ENQ_WIDTH(2), .SEL_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_en(enq_en), .enq_idx(enq_idx),
    .ready(ready),
    .flush_en(flush_en), .flush_mask(flush_mask),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_onehot(sel_onehot),
    .sel_ready(sel_ready),
    .entry_valid(entry_valid), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  sv;
    logic [3:0]  i0;
    logic [3:0]  i1;
    logic [4:0]  cnt;
    logic [15:0] ev;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] want_oh;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      want_oh = '0;
      if (mon_x.sv[0]) want_oh[mon_x.i0]      = 1'b1;
      if (mon_x.sv[1]) want_oh[16 + mon_x.i1] = 1'b1;
      chk(mon_x.nm, "sel_valid",   32'(sel_valid),    32'(mon_x.sv));
      chk(mon_x.nm, "sel_idx0",    32'(sel_idx[3:0]), 32'(mon_x.i0));
      chk(mon_x.nm, "sel_idx1",    32'(sel_idx[7:4]), 32'(mon_x.i1));
      chk(mon_x.nm, "sel_onehot",  sel_onehot,        want_oh);
      chk(mon_x.nm, "count",       32'(count),        32'(mon_x.cnt));
      chk(mon_x.nm, "entry_valid", 32'(entry_valid),  32'(mon_x.ev));
    end
  end

  // One clock of stimulus; the expectation describes outputs during this cycle.
  task automatic cyc(input string nm, input logic [1:0] en, input logic [3:0] e0, input logic [3:0] e1,
                     input logic [15:0] rd, input logic [1:0] sr, input logic fe, input logic [15:0] fm,
                     input logic rs, input logic [1:0] x_sv, input logic [3:0] x_i0, input logic [3:0] x_i1,
                     input logic [4:0] x_cnt, input logic [15:0] x_ev);
    exp_t x;
    rst        = rs;
    enq_en     = en;
    enq_idx    = {e1, e0};
    ready      = rd;
    sel_ready  = sr;
    flush_en   = fe;
    flush_mask = fm;
    x.nm = nm; x.sv = x_sv; x.i0 = x_i0; x.i1 = x_i1; x.cnt = x_cnt; x.ev = x_ev;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired with %0d expectations pending", sb.size());
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enq_en = '0; enq_idx = '0; ready = 16'hFFFF;
    sel_ready = '0; flush_en = 1'b0; flush_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    //   name            en     e0  e1  ready     sr     fe  fmask     rs   sv     i0  i1  cnt ev
    cyc("reset_idle",   2'b00, 0,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b00, 0,  0,  0,  16'h0000);
    cyc("enq5",         2'b01, 5,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b00, 0,  0,  0,  16'h0000);
    cyc("enq2",         2'b01, 2,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b01, 5,  0,  1,  16'h0020);
    cyc("enq9",         2'b01, 9,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b11, 5,  2,  2,  16'h0024);
    cyc("hold3",        2'b00, 0,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b11, 5,  2,  3,  16'h0224);
    cyc("fire_both",    2'b00, 0,  0,  16'hFFFF, 2'b11, 0, 16'h0000, 0, 2'b11, 5,  2,  3,  16'h0224);
    cyc("after_fire",   2'b00, 0,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b01, 9,  0,  1,  16'h0200);
    cyc("drain9",       2'b00, 0,  0,  16'hFFFF, 2'b01, 0, 16'h0000, 0, 2'b01, 9,  0,  1,  16'h0200);
    cyc("same_cyc_enq", 2'b11, 3,  1,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b00, 0,  0,  0,  16'h0000);
    cyc("pair_order",   2'b00, 0,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b11, 3,  1,  2,  16'h000A);
    cyc("drop_rdy3",    2'b00, 0,  0,  16'hFFF7, 2'b00, 0, 16'h0000, 0, 2'b01, 1,  0,  2,  16'h000A);
    cyc("drain_pair",   2'b00, 0,  0,  16'hFFFF, 2'b11, 0, 16'h0000, 0, 2'b11, 3,  1,  2,  16'h000A);
    cyc("enq4",         2'b01, 4,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b00, 0,  0,  0,  16'h0000);
    cyc("enq7",         2'b01, 7,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b01, 4,  0,  1,  16'h0010);
    cyc("stall_p0",     2'b00, 0,  0,  16'hFFFF, 2'b10, 0, 16'h0000, 0, 2'b11, 4,  7,  2,  16'h0090);
    cyc("after_stall",  2'b00, 0,  0,  16'hFFFF, 2'b01, 0, 16'h0000, 0, 2'b01, 4,  0,  1,  16'h0010);
    for (int k = 0; k < 8; k++) begin
      cyc("fill", 2'b11, 4'(2*k), 4'(2*k+1), 16'hFFFF, 2'b00, 0, 16'h0000, 0,
          (k == 0) ? 2'b00 : 2'b11, 4'd0, (k == 0) ? 4'd0 : 4'd1, 5'(2*k), 16'((1 << (2*k)) - 1));
    end
    cyc("full_flush",   2'b00, 0,  0,  16'hFFFF, 2'b00, 1, 16'h00FF, 0, 2'b11, 0,  1,  16, 16'hFFFF);
    cyc("post_flush",   2'b00, 0,  0,  16'hFFFF, 2'b11, 0, 16'h0000, 0, 2'b11, 8,  9,  8,  16'hFF00);
    cyc("enq5b",        2'b01, 5,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b11, 10, 11, 6,  16'hFC00);
    cyc("collide",      2'b01, 5,  0,  16'h1020, 2'b10, 1, 16'h0420, 0, 2'b11, 12, 5,  7,  16'hFC20);
    cyc("reuse_young",  2'b00, 0,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b11, 11, 12, 6,  16'hF820);
    cyc("young_low",    2'b00, 0,  0,  16'h8020, 2'b01, 1, 16'h8000, 0, 2'b11, 15, 5,  6,  16'hF820);
    cyc("rdy_no_vld",   2'b00, 0,  0,  16'h0800, 2'b10, 0, 16'h0000, 0, 2'b01, 11, 0,  5,  16'h7820);
    cyc("mid_reset",    2'b01, 0,  0,  16'hFFFF, 2'b11, 1, 16'h0800, 1, 2'b11, 11, 12, 5,  16'h7820);
    cyc("post_reset",   2'b00, 0,  0,  16'hFFFF, 2'b00, 0, 16'h0000, 0, 2'b00, 0,  0,  0,  16'h0000);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/age_matrix_multi_selector.md
Name: age_matrix_multi_selector

Overview:
- Multi-port oldest-first selector for issue queues.
- Keeps a per-entry valid vector and a DEPTH x DEPTH age matrix, updated by multi-port enqueue.
- Each cycle it presents the SEL_WIDTH oldest ready entries on independent select ports, each with a valid/ready handshake that frees the entry.
- Supports masked flush. Sits between issue-queue entry storage and the execution-unit issue ports.

Parameters:
DEPTH, 16, number of tracked entries (>=2)
ENQ_WIDTH, 2, enqueue ports per cycle
SEL_WIDTH, 2, select/issue ports per cycle (1..DEPTH)
IDX_WIDTH, $clog2(DEPTH), entry index width
CNT_WIDTH, $clog2(DEPTH+1), occupancy count width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
enq_en  in  ENQ_WIDTH  per-port allocate strobe
enq_idx  in  ENQ_WIDTH x IDX_WIDTH  entry allocated by each port
ready  in  DEPTH  operand-ready per entry (combinational from queue)
flush_en  in  1  flush strobe
flush_mask  in  DEPTH  entries to invalidate when flush_en=1
sel_valid  out  SEL_WIDTH  port k holds a selected entry
sel_idx  out  SEL_WIDTH x IDX_WIDTH  selected entry index
sel_onehot  out  SEL_WIDTH x DEPTH  one-hot form of sel_idx
sel_ready  in  SEL_WIDTH  downstream accepts port k this cycle
entry_valid  out  DEPTH  occupancy vector
count  out  CNT_WIDTH  popcount(entry_valid)

Behaviour:
- Reset (rst=1 at edge): entry_valid=0, age matrix=0, count=0. Outputs then give sel_valid=0, sel_idx=0, sel_onehot=0.
- Age matrix: older[i][j]=1 means i is older than j. Only pairs with both entries valid are meaningful; the diagonal is ignored.
- Eligibility: elig[i] = entry_valid[i] & ready[i]. Entries enqueued this cycle are not eligible until the next cycle.
- Selection is combinational, zero latency from ready/entry_valid.
  - rank[i] = number of eligible j with older[j][i]=1.
  - Port k selects the unique eligible i with rank[i]==k.
  - sel_valid[k] = (number of eligible entries > k).
  - The ports therefore hold distinct entries in strict age order: port 0 is the oldest.
  - If sel_valid[k]=0, then sel_idx[k]=0 and sel_onehot[k]=0.
- Issue handshake: fire[k] = sel_valid[k] & sel_ready[k]. A fired entry has entry_valid cleared at the next edge.
  - Not fired: the entry stays valid and is re-ranked next cycle.
  - sel_ready[k] without sel_valid[k] has no effect.
  - Lower ports may stall while higher ports fire.
- Enqueue of port p (enq_en[p]=1, index e):
  - Next cycle entry_valid[e]=1.
  - older[e][*]=0 and older[*][e]=1, so e is younger than every existing entry.
  - Same-cycle enqueues: a lower port number is older. For p<q, older[idx_p][idx_q]=1 and older[idx_q][idx_p]=0.
- Flush: when flush_en=1, entry_valid[i] is cleared for every flush_mask[i]=1. The age matrix is untouched.
- Simultaneous events on the same entry:
  - Enqueue beats flush and beats fire-free: the entry ends valid and youngest, because flush and fire apply only to prior contents.
  - Fire plus flush: the entry ends invalid.
  - Select outputs in a flush cycle are still driven; the consumer must gate them.
- count = popcount of the next-state entry_valid, registered alongside it. Range 0..DEPTH.
  - DEPTH is reachable (full) with no wrap.
  - Index reuse after free is unrestricted; a reused index is always youngest.
- Illegal inputs, checked by simulation assertions (no RTL recovery):
  - Enqueue to an entry that is valid and not fired or flushed this cycle.
  - Two enqueue ports with the same index in one cycle.
  - Enqueue while count plus the number of enqueues minus frees would exceed DEPTH.
- Reset mid-operation: all state clears at that edge. Enqueue, fire and flush in the reset cycle are ignored.

Test Plan:
- Reset, then idle with ready=all-ones -> sel_valid=00, count=0, entry_valid=0.
- Enqueue 5, then 2, then 9 on port 0 in consecutive cycles, ready=all-ones, sel_ready=00 -> sel_idx0=5, sel_idx1=2, sel_valid=11, count=3. Set sel_ready=11 -> next cycle sel_idx0=9, sel_valid=01, count=1.
- Same-cycle enqueue: port0=3, port1=1 -> next cycle sel_idx0=3, sel_idx1=1. Drop ready[3] -> sel_idx0=1, sel_valid=01.
- Handshake stall: entries 4 (older), 7; sel_ready=10 -> entry 7 freed, 4 stays; next cycle sel_idx0=4, count=1.
- Fill: 16 enqueues over 8 cycles -> count=16, entry_valid=FFFF. Flush_mask=0x00FF -> count=8, and the oldest surviving enqueued entry appears on port 0.
- Reuse and collision: fire entry 5, re-enqueue 5 in the same cycle, alongside a flush covering bit 5 -> 5 stays valid and becomes youngest (lowest priority among ready entries).
